// File: rtl/a2d_scan_sched.sv
`timescale 1ns/1ps
// a2d_scan_sched: round-robin conversion scheduler for the shared A2D interface,
// with a one-deep forced request that jumps the queue and a per-channel result store.
module a2d_scan_sched #(
    parameter int NUM_CHNNL = 7,
    parameter int RES_W     = 12,
    parameter int GAP_CYC   = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             force_req,
    input  logic [2:0]       force_chnnl,
    output logic             strt_cnv,
    output logic [2:0]       chnnl,
    input  logic             cnv_cmplt,
    input  logic [RES_W-1:0] res,
    input  logic [2:0]       rd_chnnl,
    output logic [RES_W-1:0] rd_data,
    output logic             rd_vld,
    output logic             busy,
    output logic             scan_done,
    output logic             timeout
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam int GCNT_W = $clog2(GAP_CYC + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [GCNT_W-1:0] GAP_LAST  = GCNT_W'(GAP_CYC - 1);
    localparam logic [2:0]        LAST_CH   = 3'(NUM_CHNNL - 1);
    localparam logic [3:0]        NUM_CH4   = 4'(NUM_CHNNL);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [WCNT_W-1:0] wait_cnt_r;
    logic [GCNT_W-1:0] gap_cnt_r;
    logic [2:0]        rr_ptr_r;
    logic [2:0]        pend_chnnl_r;
    logic [2:0]        sel_ch_s;
    logic              pend_r;
    logic              cur_force_r;
    logic              force_ok_s;
    logic              go_s;
    logic              wr_s;
    logic              wait_end_s;
    logic              sel_force_s;
    logic              enter_start_s;
    logic [RES_W-1:0]  result_r [NUM_CHNNL];
    logic [NUM_CHNNL-1:0] valid_r;

    // Request qualification; a force arriving on the START-entry edge is taken directly
    always_comb begin
        force_ok_s  = force_req & ({1'b0, force_chnnl} < NUM_CH4);
        go_s        = en | pend_r;
        wr_s        = (state_r == WAIT) & cnv_cmplt;
        wait_end_s  = (state_r == WAIT) & (cnv_cmplt | (wait_cnt_r == WAIT_LAST));
        sel_force_s = pend_r | force_ok_s;
        if (force_ok_s) begin
            sel_ch_s = force_chnnl;
        end else if (pend_r) begin
            sel_ch_s = pend_chnnl_r;
        end else begin
            sel_ch_s = rr_ptr_r;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = go_s ? START : IDLE;
            START:   state_nxt_s = WAIT;
            WAIT:    state_nxt_s = wait_end_s ? GAP : WAIT;
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_nxt_s = go_s ? START : IDLE;
                end else begin
                    state_nxt_s = GAP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
        enter_start_s = (state_nxt_s == START);
    end

    // FSM state, counters, pointer, pending request and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            wait_cnt_r   <= '0;
            gap_cnt_r    <= '0;
            rr_ptr_r     <= 3'd0;
            pend_r       <= 1'b0;
            pend_chnnl_r <= 3'd0;
            cur_force_r  <= 1'b0;
            strt_cnv     <= 1'b0;
            chnnl        <= 3'd0;
            busy         <= 1'b0;
            scan_done    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= (state_r == WAIT) ? wait_cnt_r + WCNT_W'(1) : '0;
            gap_cnt_r  <= (state_r == GAP) ? gap_cnt_r + GCNT_W'(1) : '0;
            strt_cnv   <= enter_start_s;
            busy       <= (state_nxt_s != IDLE);
            scan_done  <= wait_end_s & ~cur_force_r & (chnnl == LAST_CH);
            timeout    <= (state_r == WAIT) & ~cnv_cmplt & (wait_cnt_r == WAIT_LAST);
            if (enter_start_s) begin
                chnnl       <= sel_ch_s;
                cur_force_r <= sel_force_s;
            end
            // Entering START consumes any pending or coinciding force request
            if (enter_start_s) begin
                pend_r <= 1'b0;
            end else if (force_ok_s) begin
                pend_r       <= 1'b1;
                pend_chnnl_r <= force_chnnl;
            end
            if (wait_end_s && !cur_force_r) begin
                rr_ptr_r <= (rr_ptr_r == LAST_CH) ? 3'd0 : rr_ptr_r + 3'd1;
            end
        end
    end

    // Per-channel result store, written only on a completion seen in WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            for (int i = 0; i < NUM_CHNNL; i++) begin
                result_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHNNL; i++) begin
                if (wr_s && (chnnl == 3'(i))) begin
                    result_r[i] <= res;
                    valid_r[i]  <= 1'b1;
                end
            end
        end
    end

    // AND-OR read mux; out-of-range addresses select nothing and read as zero
    always_comb begin
        rd_data = '0;
        rd_vld  = 1'b0;
        for (int i = 0; i < NUM_CHNNL; i++) begin
            rd_data = rd_data | ({RES_W{rd_chnnl == 3'(i)}} & result_r[i]);
            rd_vld  = rd_vld | ((rd_chnnl == 3'(i)) & valid_r[i]);
        end
    end

endmodule

// File: tb/tb_a2d_scan_sched.sv
`timescale 1ns/1ps
// tb_a2d_scan_sched: A2D model plus channel-order scoreboard, read-port vector table
// and hand-written sequences for force, timeout, enable-drop and mid-flight reset.
module tb_a2d_scan_sched;
    localparam int NUM_CHNNL = 7;
    localparam int RES_W     = 12;
    localparam int GAP_CYC   = 16;
    localparam int TIMEOUT   = 1024;
    localparam int A2D_LAT   = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             force_req;
    logic [2:0]       force_chnnl;
    logic             strt_cnv;
    logic [2:0]       chnnl;
    logic             cnv_cmplt;
    logic [RES_W-1:0] res;
    logic [2:0]       rd_chnnl;
    logic [RES_W-1:0] rd_data;
    logic             rd_vld;
    logic             busy;
    logic             scan_done;
    logic             timeout;

    always #5 clk = ~clk;

    a2d_scan_sched #(
        .NUM_CHNNL(NUM_CHNNL), .RES_W(RES_W), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .force_req(force_req), .force_chnnl(force_chnnl),
        .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .res(res),
        .rd_chnnl(rd_chnnl), .rd_data(rd_data), .rd_vld(rd_vld), .busy(busy),
        .scan_done(scan_done), .timeout(timeout)
    );

    typedef struct {
        logic [2:0]       ch;
        logic [RES_W-1:0] data;
        logic             vld;
    } rd_vec_t;

    rd_vec_t rd_tbl [16];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_starts = 0;
    int n_scan = 0;
    int n_tmo = 0;
    int tmo_cyc = 0;
    int last_start_cyc = 0;
    int remain = 0;
    int t1 = 0;
    logic [2:0]       cnv_ch = 3'd0;
    logic [3:0]       silent_ch = 4'hf;
    logic [RES_W-1:0] res_base = 12'h100;
    int exp_q[$];
    int start_cyc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: A2D model answers A2D_LAT clks after strt_cnv, then scoreboard sampling
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        cnv_cmplt = 1'b0;
        if (strt_cnv === 1'b1) begin
            remain = A2D_LAT;
            cnv_ch = chnnl;
        end else if (remain > 0) begin
            remain--;
            if (remain == 0 && {1'b0, cnv_ch} != silent_ch) begin
                cnv_cmplt = 1'b1;
                res = res_base + 12'(cnv_ch);
            end
        end
        if (strt_cnv === 1'b1) begin
            n_starts++;
            last_start_cyc = cyc;
            start_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_start", 32'(strt_cnv), 32'd0);
            end else begin
                chk("start_chnnl", 32'(chnnl), 32'(exp_q.pop_front()));
            end
        end
        if (scan_done === 1'b1) n_scan++;
        if (timeout === 1'b1) begin
            n_tmo++;
            tmo_cyc = cyc;
        end
    endtask

    task automatic wait_starts(input int n, input string name);
        int k;
        k = 0;
        while (n_starts < n && k < 2000) begin
            tick();
            k++;
        end
        chk(name, 32'(n_starts), 32'(n));
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 300) begin
            tick();
            k++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic apply_rd(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            rd_chnnl = rd_tbl[i].ch;
            tick();
            chk($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(rd_tbl[i].data));
            chk($sformatf("rd_vld[%0d]", i), 32'(rd_vld), 32'(rd_tbl[i].vld));
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_strt_cnv"}, 32'(strt_cnv), 32'd0);
        chk({tag, "_chnnl"}, 32'(chnnl), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_scan_done"}, 32'(scan_done), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; force_req = 1'b0; force_chnnl = 3'd0;
        cnv_cmplt = 1'b0; res = '0; rd_chnnl = 3'd0;
        for (int i = 0; i < NUM_CHNNL; i++) begin
            rd_tbl[i] = '{ch: 3'(i), data: 12'h100 + 12'(i), vld: 1'b1};
        end
        rd_tbl[7] = '{ch: 3'd7, data: 12'h000, vld: 1'b0};
        for (int i = 0; i < 8; i++) begin
            rd_tbl[8 + i] = '{ch: 3'(i), data: 12'h000, vld: 1'b0};
        end

        tick(); tick();
        chk_quiet("reset");
        rst = 1'b0;

        // Full round-robin pass and wrap back to channel 0
        for (int c = 0; c < NUM_CHNNL; c++) exp_q.push_back(c);
        exp_q.push_back(0);
        en = 1'b1;
        wait_starts(8, "scan_starts");
        for (int i = 1; i < 8; i++) begin
            chk("rr_spacing", 32'(start_cyc_q[i] - start_cyc_q[i-1]), 32'(1 + A2D_LAT + GAP_CYC));
        end
        chk("scan_done_pass1", 32'(n_scan), 32'd1);
        exp_q.push_back(1); exp_q.push_back(2);
        apply_rd(0, 8);

        // Force ch5 while RR waits on ch2, then RR resumes at ch3
        wait_starts(10, "rr_to_ch2");
        tick(); tick();
        force_req = 1'b1; force_chnnl = 3'd5;
        tick();
        force_req = 1'b0;
        exp_q.push_back(5); exp_q.push_back(3);
        wait_starts(12, "force_then_rr");
        rd_chnnl = 3'd5;
        tick();
        chk("force_rd_vld5", 32'(rd_vld), 32'd1);
        chk("force_rd_data5", 32'(rd_data), 32'h105);

        // Drop en during WAIT on ch6
        exp_q.push_back(4); exp_q.push_back(5); exp_q.push_back(6);
        wait_starts(15, "rr_to_ch6");
        tick(); tick();
        en = 1'b0;
        res_base = 12'h200;
        wait_idle("en_drop_idle");
        chk("scan_done_en_drop", 32'(n_scan), 32'd2);
        rd_chnnl = 3'd6;
        tick();
        chk("en_drop_rd_data6", 32'(rd_data), 32'h206);

        // Pointer wrapped to 0; reset during that WAIT, completion arrives afterwards
        exp_q.push_back(0);
        en = 1'b1;
        wait_starts(16, "ptr_wrapped_ch0");
        tick(); tick();
        rst = 1'b1; en = 1'b0;
        tick();
        chk_quiet("midrst");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        apply_rd(8, 16);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // A2D silent on ch1: timeout, no store, RR moves on to ch2
        silent_ch = 4'd1;
        res_base = 12'h100;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        en = 1'b1;
        wait_starts(18, "ch1_start");
        t1 = last_start_cyc;
        for (int k = 0; k < TIMEOUT + 100 && n_tmo == 0; k++) tick();
        chk("timeout_seen", 32'(n_tmo), 32'd1);
        chk("timeout_delay", 32'(tmo_cyc - t1), 32'(TIMEOUT + 1));
        wait_starts(19, "after_timeout_ch2");
        rd_chnnl = 3'd1;
        tick();
        chk("timeout_rd_vld1", 32'(rd_vld), 32'd0);
        en = 1'b0;
        wait_idle("tmo_idle");
        silent_ch = 4'hf;

        // Idle forces: ch4 then ch6 back to back, only ch6 converts; ch7 is ignored
        exp_q.push_back(6);
        force_req = 1'b1; force_chnnl = 3'd4;
        tick();
        force_chnnl = 3'd6;
        tick();
        force_req = 1'b0;
        wait_idle("force_idle");
        chk("force_only_ch6", 32'(n_starts), 32'd20);
        force_req = 1'b1; force_chnnl = 3'd7;
        tick();
        force_req = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk("force_oor_busy", 32'(busy), 32'd0);
        chk("force_oor_no_start", 32'(n_starts), 32'd20);
        chk("scan_done_total", 32'(n_scan), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
